// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiply/round core among NUM_REQ requesters.
// Results return in issue order, tagged with the owner ID carried through a latency-matched pipe.
module fp_mult_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CORE_LAT = 2,
  parameter int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_rnd,
  output logic                  core_valid,
  output logic [31:0]           core_a,
  output logic [31:0]           core_b,
  output logic [2:0]            core_rnd,
  input  logic [31:0]           core_z,
  input  logic [7:0]            core_status,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_z,
  output logic [7:0]            resp_status,
  output logic                  busy
);

  logic [ID_W-1:0]  last_q;
  logic             core_valid_q;
  logic [31:0]      core_a_q;
  logic [31:0]      core_b_q;
  logic [2:0]       core_rnd_q;
  logic [ID_W-1:0]  core_id_q;
  logic [CORE_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0]  tag_id_q [CORE_LAT];
  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [31:0]      resp_z_q;
  logic [7:0]       resp_status_q;

  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  logic             hs;
  logic [2:0]       rnd_raw;
  logic [2:0]       rnd_san;

  // Search starts one past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (!win_vld && req_valid[sel]) begin
        win_vld = 1'b1;
        win_id  = sel;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && win_vld) begin
      req_ready = NUM_REQ'(1) << win_id;
    end
  end

  assign hs      = rst & win_vld;
  assign rnd_raw = req_rnd[3*win_id +: 3];
  // Encodings 6 and 7 are undefined for the core; it treats them as round-to-nearest.
  assign rnd_san = (rnd_raw > 3'd5) ? 3'd0 : rnd_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q        <= ID_W'(NUM_REQ - 1);
      core_valid_q  <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      core_rnd_q    <= 3'd0;
      core_id_q     <= '0;
      tag_vld_q     <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_id_q[i] <= '0;
      end
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_z_q      <= '0;
      resp_status_q <= '0;
    end else begin
      core_valid_q <= hs;
      if (hs) begin
        last_q     <= win_id;
        core_a_q   <= req_a[32*win_id +: 32];
        core_b_q   <= req_b[32*win_id +: 32];
        core_rnd_q <= rnd_san;
        core_id_q  <= win_id;
      end
      tag_vld_q[0] <= core_valid_q;
      tag_id_q[0]  <= core_id_q;
      for (int i = 1; i < CORE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      resp_valid_q <= tag_vld_q[CORE_LAT-1];
      if (tag_vld_q[CORE_LAT-1]) begin
        resp_id_q     <= tag_id_q[CORE_LAT-1];
        resp_z_q      <= core_z;
        resp_status_q <= core_status;
      end
    end
  end

  assign core_valid  = core_valid_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign core_rnd    = core_rnd_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_z      = resp_z_q;
  assign resp_status = resp_status_q;
  assign busy        = core_valid_q | (|tag_vld_q) | resp_valid_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter with a table-driven stand-in multiplier core.
module tb_fp_mult_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned CORE_LAT = 2;
  localparam int unsigned ID_W     = 2;

  // Directed vectors: operands, requested mode, product and sanitised mode.
  localparam logic [31:0] VA [6] = '{32'h3F800000, 32'h3FC00000, 32'h40400000,
                                     32'hC0000000, 32'h40800000, 32'h40A00000};
  localparam logic [31:0] VB [6] = '{32'h40000000, 32'h40000000, 32'h3F000000,
                                     32'h40000000, 32'h3E800000, 32'h40000000};
  localparam logic [31:0] VZ [6] = '{32'h40000000, 32'h40400000, 32'h3FC00000,
                                     32'hC0800000, 32'h3F800000, 32'h41200000};
  localparam logic [2:0]  VR [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd5};
  localparam logic [2:0]  VS [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5};

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a = '0;
  logic [NUM_REQ*32-1:0] req_b = '0;
  logic [NUM_REQ*3-1:0]  req_rnd = '0;
  logic                  core_valid;
  logic [31:0]           core_a;
  logic [31:0]           core_b;
  logic [2:0]            core_rnd;
  logic [31:0]           core_z;
  logic [7:0]            core_status;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_z;
  logic [7:0]            resp_status;
  logic                  busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     z;
    logic [7:0]      st;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  fp_mult_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CORE_LAT (CORE_LAT),
    .ID_W     (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rnd     (req_rnd),
    .core_valid  (core_valid),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_rnd    (core_rnd),
    .core_z      (core_z),
    .core_status (core_status),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_z      (resp_z),
    .resp_status (resp_status),
    .busy        (busy)
  );

  // Stand-in core: looks up the product of known operand pairs, status echoes the mode.
  logic [31:0] cm_z  [CORE_LAT];
  logic [7:0]  cm_st [CORE_LAT];

  function automatic logic [31:0] model_mul(logic [31:0] a, logic [31:0] b);
    for (int i = 0; i < 6; i++) begin
      if (a == VA[i] && b == VB[i]) return VZ[i];
    end
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    cm_z[0]  <= core_valid ? model_mul(core_a, core_b) : 32'hBAD0BAD0;
    cm_st[0] <= core_valid ? {5'b0, core_rnd} : 8'hEE;
    for (int i = 1; i < CORE_LAT; i++) begin
      cm_z[i]  <= cm_z[i-1];
      cm_st[i] <= cm_st[i-1];
    end
  end
  assign core_z      = cm_z[CORE_LAT-1];
  assign core_status = cm_st[CORE_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response must match the head of the expected queue.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got id %0d z %h, want no response at %0t",
                 resp_id, resp_z, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_z", resp_z, e.z);
        check("resp_status", 32'(resp_status), 32'(e.st));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int v, input logic vld);
    req_valid[r]     = vld;
    req_a[32*r +: 32] = VA[v];
    req_b[32*r +: 32] = VB[v];
    req_rnd[3*r +: 3] = VR[v];
  endtask

  task automatic push(input int id, input int v);
    exp_t e;
    e.id = ID_W'(id);
    e.z  = VZ[v];
    e.st = {5'b0, VS[v]};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Leaves the bench at +1 after the edge that starts the first post-reset cycle.
  task automatic do_reset();
    step();
    rst = 1'b0;
    drive(0, 0, 1'b1);
    drive(2, 1, 1'b1);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    check("rst_ready2", 32'(req_ready), 32'd0);
    check("rst_core_valid", 32'(core_valid), 32'd0);
    check("rst_core_a", core_a, 32'd0);
    check("rst_core_rnd", 32'(core_rnd), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_z", resp_z, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] wrap_g [3];
    wrap_g[0] = 4'b0010;
    wrap_g[1] = 4'b1000;
    wrap_g[2] = 4'b0010;

    // Single request, first cycle after reset.
    do_reset();
    drive(0, 0, 1'b1);
    push(0, 0);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0001);
    check("single_busy_t0", 32'(busy), 32'd0);
    step();
    req_valid = '0;
    @(negedge clk);
    check("single_core_valid", 32'(core_valid), 32'd1);
    check("single_core_a", core_a, 32'h3F800000);
    check("single_core_b", core_b, 32'h40000000);
    check("single_core_rnd", 32'(core_rnd), 32'd0);
    check("single_busy_t1", 32'(busy), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step();
      @(negedge clk);
      check("single_resp_valid", 32'(resp_valid), (k == 4) ? 32'd1 : 32'd0);
      check("single_busy", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
      check("single_core_idle", 32'(core_valid), 32'd0);
    end
    drain();

    // Contention between requesters 0 and 1.
    do_reset();
    drive(0, 1, 1'b1);
    drive(1, 2, 1'b1);
    for (int i = 0; i < 6; i++) push(i % 2, (i % 2 == 0) ? 1 : 2);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step();
      if (c == 6) req_valid = '0;
      @(negedge clk);
      if (c < 7) check("cont_ready", 32'(req_ready),
                       (c == 6) ? 32'd0 : ((c % 2 == 0) ? 32'b0001 : 32'b0010));
      check("cont_resp_valid", 32'(resp_valid), (c >= 4 && c <= 9) ? 32'd1 : 32'd0);
    end
    drain();

    // Wrap-around from last=3 with requesters 1 and 3.
    do_reset();
    drive(1, 3, 1'b1);
    drive(3, 5, 1'b1);
    push(1, 3);
    push(3, 5);
    push(1, 3);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      @(negedge clk);
      check("wrap_ready", 32'(req_ready), 32'(wrap_g[c]));
    end
    step();
    req_valid = '0;
    drain();

    // Illegal rounding mode 7 issued as nearest.
    step();
    drive(1, 4, 1'b1);
    push(1, 4);
    @(negedge clk);
    check("illegal_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("illegal_core_rnd", 32'(core_rnd), 32'd0);
    check("illegal_core_a", core_a, 32'h40800000);
    drain();

    // Reset while a result is in flight.
    step();
    drive(0, 0, 1'b1);
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    drive(1, 2, 1'b1);
    @(negedge clk);
    check("midrst_ready_in_rst", 32'(req_ready), 32'd0);
    step();
    rst = 1'b1;
    req_valid = '0;
    for (int c = 3; c <= 8; c++) begin
      if (c > 3) step();
      @(negedge clk);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
    end
    step();
    drive(0, 0, 1'b1);
    drive(1, 1, 1'b1);
    push(0, 0);
    @(negedge clk);
    check("midrst_first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    drain();

    // Idle: nothing moves and registered data holds.
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_core_valid", 32'(core_valid), 32'd0);
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
    end
    check("idle_core_a", core_a, 32'h3F800000);
    check("idle_core_b", core_b, 32'h40000000);
    check("idle_resp_z", resp_z, 32'h40000000);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
